// File: rtl/gate_lib_pkg.sv
// ============================================================================
// Module  : gate_lib_pkg
// Purpose : Shared types and truth-table constants for gate-cell sweeps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_lib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int TT_W = 4;

  // Truth tables indexed by {a,b}: bit n holds y for input vector n.
  localparam logic [TT_W-1:0] NOR2_TT  = 4'b0001;
  localparam logic [TT_W-1:0] OR2_TT   = 4'b1110;
  localparam logic [TT_W-1:0] AND2_TT  = 4'b1000;
  localparam logic [TT_W-1:0] NAND2_TT = 4'b0111;
  localparam logic [TT_W-1:0] XOR2_TT  = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// ============================================================================
// Module  : settle_timer
// Purpose : Loadable down-counter; o_tc is high while the count is zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
// ============================================================================
// Module  : gate_sweep_ctrl
// Purpose : Sweeps a 2-input gate through all vectors and checks its table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_ctrl
  import gate_lib_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8,
  parameter int SWEEP_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_cont,
  input  logic               i_abort,
  input  logic [TT_W-1:0]    i_expect_tt,
  output logic               o_gate_a,
  output logic               o_gate_b,
  input  logic               i_gate_y,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [TT_W-1:0]    o_result_tt,
  output logic [ERR_W-1:0]   o_err_cnt,
  output logic [SWEEP_W-1:0] o_sweep_cnt
);

  localparam int               TMR_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TMR_W-1:0] c_TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_idx;
  logic [1:0]           r_gate;
  logic [TT_W-1:0]      r_tt;
  logic [TT_W-1:0]      r_exp;
  logic [TT_W-1:0]      r_result_tt;
  logic                 r_cont;
  logic                 r_pass;
  logic [ERR_W-1:0]     r_err;
  logic [SWEEP_W-1:0]   r_sweep;

  logic w_tmr_load;
  logic w_tmr_en;
  logic w_tmr_tc;
  logic w_start_run;
  logic w_sample;
  logic w_check;
  logic w_restart;
  logic w_match;

  settle_timer #(
    .W (TMR_W)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_en   (w_tmr_en),
    .i_val  (c_TMR_LOAD),
    .o_tc   (w_tmr_tc)
  );

  assign w_match = (r_tt == r_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    w_start_run = 1'b0;
    w_sample    = 1'b0;
    w_check     = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SETTLE;
          w_start_run = 1'b1;
          w_tmr_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        w_tmr_en = 1'b1;
        if (w_tmr_tc) begin
          w_sample = 1'b1;
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_tmr_load = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        w_check = 1'b1;
        if (r_cont && i_cont) begin
          w_state_nxt = ST_SETTLE;
          w_restart   = 1'b1;
          w_tmr_load  = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Abort cancels every pending update so the last reported results survive.
    if (i_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_tmr_load  = 1'b0;
      w_start_run = 1'b0;
      w_sample    = 1'b0;
      w_check     = 1'b0;
      w_restart   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= 2'd0;
      r_gate      <= 2'd0;
      r_tt        <= '0;
      r_exp       <= '0;
      r_result_tt <= '0;
      r_cont      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_sweep     <= '0;
    end else begin
      if (w_start_run) begin
        r_exp   <= i_expect_tt;
        r_cont  <= i_cont;
        r_err   <= '0;
        r_sweep <= '0;
        r_idx   <= 2'd0;
        r_gate  <= 2'd0;
      end
      if (w_sample) begin
        r_tt[r_idx] <= i_gate_y;
        if (r_idx == 2'd3) begin
          r_gate <= 2'd0;
        end else begin
          r_idx  <= r_idx + 2'd1;
          r_gate <= r_idx + 2'd1;
        end
      end
      if (w_check) begin
        r_result_tt <= r_tt;
        r_pass      <= w_match;
        r_sweep     <= r_sweep + SWEEP_W'(1);
        if (!w_match && (r_err != '1)) begin
          r_err <= r_err + ERR_W'(1);
        end
        if (!i_cont) begin
          r_cont <= 1'b0;
        end
      end
      if (w_restart) begin
        r_idx  <= 2'd0;
        r_gate <= 2'd0;
      end
      if (i_abort && (r_state != ST_IDLE)) begin
        r_gate <= 2'd0;
      end
    end
  end

  assign o_gate_a    = r_gate[1];
  assign o_gate_b    = r_gate[0];
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_pass      = r_pass;
  assign o_result_tt = r_result_tt;
  assign o_err_cnt   = r_err;
  assign o_sweep_cnt = r_sweep;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
// ============================================================================
// Module  : tb_gate_sweep_ctrl
// Purpose : Directed self-checking bench for gate_sweep_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_ctrl;
  import gate_lib_pkg::*;

  localparam int ERR_W   = 2;
  localparam int SWEEP_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic               i_cont;
  logic               i_abort;
  logic [TT_W-1:0]    i_expect_tt;
  logic               o_gate_a;
  logic               o_gate_b;
  logic               i_gate_y;
  logic               o_busy;
  logic               o_done;
  logic               o_pass;
  logic [TT_W-1:0]    o_result_tt;
  logic [ERR_W-1:0]   o_err_cnt;
  logic [SWEEP_W-1:0] o_sweep_cnt;

  // 0: NOR2 cell, 1: output stuck at 1, 2: output stuck at 0
  logic [1:0] r_mode;

  typedef struct packed {
    logic [TT_W-1:0]    tt;
    logic               pass;
    logic [ERR_W-1:0]   err;
    logic [SWEEP_W-1:0] sweep;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (r_mode)
      2'd0:    i_gate_y = ~(o_gate_a | o_gate_b);
      2'd1:    i_gate_y = 1'b1;
      default: i_gate_y = 1'b0;
    endcase
  end

  gate_sweep_ctrl #(
    .SETTLE_CYCLES (2),
    .ERR_W         (ERR_W),
    .SWEEP_W       (SWEEP_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_cont      (i_cont),
    .i_abort     (i_abort),
    .i_expect_tt (i_expect_tt),
    .o_gate_a    (o_gate_a),
    .o_gate_b    (o_gate_b),
    .i_gate_y    (i_gate_y),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_result_tt (o_result_tt),
    .o_err_cnt   (o_err_cnt),
    .o_sweep_cnt (o_sweep_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gates"}, {30'd0, o_gate_a, o_gate_b}, 32'd0);
    chk({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, o_done}, 32'd0);
    chk({tag, "_pass"},  {31'd0, o_pass}, 32'd0);
    chk({tag, "_tt"},    {28'd0, o_result_tt}, 32'd0);
    chk({tag, "_err"},   {30'd0, o_err_cnt}, 32'd0);
    chk({tag, "_sweep"}, {16'd0, o_sweep_cnt}, 32'd0);
  endtask

  // Pulses start for the edge that launches the run; expect_tt is then scrambled.
  task automatic launch(input logic [TT_W-1:0] exp_tt, input logic cont);
    i_expect_tt = exp_tt;
    i_cont      = cont;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
    i_expect_tt = ~exp_tt;
  endtask

  // Caller is in cycle start_cnt after the start edge; returns the done cycle.
  task automatic wait_done(input int start_cnt, output int lat);
    int cnt;
    cnt = start_cnt;
    while (!o_done && cnt < 200) begin
      tick();
      cnt++;
    end
    lat = cnt;
    if (!o_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: observed no done after %0d cycles, required a done pulse", cnt);
    end
  endtask

  task automatic score(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_sb_empty: observed empty scoreboard, required one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_tt"},    {28'd0, o_result_tt}, {28'd0, e.tt});
      chk({tag, "_pass"},  {31'd0, o_pass}, {31'd0, e.pass});
      chk({tag, "_err"},   {30'd0, o_err_cnt}, {30'd0, e.err});
      chk({tag, "_sweep"}, {16'd0, o_sweep_cnt}, {16'd0, e.sweep});
    end
  endtask

  initial begin
    int lat;
    int n_done;
    int first_done;

    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_cont      = 1'b0;
    i_abort     = 1'b0;
    i_expect_tt = '0;
    r_mode      = 2'd0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // NOR2 sweep with matching expectation; vectors held two cycles each
    sb.push_back('{tt: NOR2_TT, pass: 1'b1, err: 2'd0, sweep: 16'd1});
    launch(NOR2_TT, 1'b0);
    chk("t1_busy", {31'd0, o_busy}, 32'd1);
    for (int v = 0; v < 4; v++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("t1_vec%0d_%0d", v, c), {30'd0, o_gate_a, o_gate_b}, v);
        tick();
      end
    end
    wait_done(9, lat);
    chk("t1_latency", lat, 32'd10);
    score("t1");
    tick();
    chk("t1_done_pulse", {31'd0, o_done}, 32'd0);
    chk("t1_idle", {31'd0, o_busy}, 32'd0);

    // NOR2 against an AND2 expectation
    sb.push_back('{tt: NOR2_TT, pass: 1'b0, err: 2'd1, sweep: 16'd1});
    launch(AND2_TT, 1'b0);
    wait_done(1, lat);
    chk("t2_latency", lat, 32'd10);
    score("t2");
    tick();

    // Stuck-at-1 output
    r_mode = 2'd1;
    sb.push_back('{tt: 4'b1111, pass: 1'b0, err: 2'd1, sweep: 16'd1});
    launch(NOR2_TT, 1'b0);
    wait_done(1, lat);
    score("t3");
    tick();

    // Stuck-at-0, continuous mode for five sweeps; err_cnt saturates at 3
    r_mode = 2'd2;
    sb.push_back('{tt: 4'b0000, pass: 1'b0, err: 2'd3, sweep: 16'd5});
    launch(NOR2_TT, 1'b1);
    n_done     = 0;
    first_done = 0;
    for (int cnt = 1; cnt <= 60; cnt++) begin
      if (cnt == 40) i_cont = 1'b0;
      if (o_done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = cnt;
          score("t4");
        end
      end
      tick();
    end
    chk("t4_done_count", n_done, 32'd1);
    chk("t4_done_cycle", first_done, 32'd46);

    // Passing run to establish known results before the aborted one
    r_mode = 2'd0;
    sb.push_back('{tt: NOR2_TT, pass: 1'b1, err: 2'd0, sweep: 16'd1});
    launch(NOR2_TT, 1'b0);
    wait_done(1, lat);
    score("t5_pre");
    tick();

    // Abort during the third vector; a start mid-run must be ignored
    r_mode = 2'd1;
    launch(AND2_TT, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_vec2", {30'd0, o_gate_a, o_gate_b}, 32'd2);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("t5_busy", {31'd0, o_busy}, 32'd0);
    chk("t5_gates", {30'd0, o_gate_a, o_gate_b}, 32'd0);
    chk("t5_tt", {28'd0, o_result_tt}, {28'd0, NOR2_TT});
    chk("t5_pass", {31'd0, o_pass}, 32'd1);
    chk("t5_sweep", {16'd0, o_sweep_cnt}, 32'd0);
    n_done = 0;
    for (int cnt = 0; cnt < 12; cnt++) begin
      if (o_done) n_done++;
      tick();
    end
    chk("t5_no_done", n_done, 32'd0);

    // Reset mid-sweep, then a clean sweep
    launch(NOR2_TT, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("t6_rst");
    rst_n  = 1'b1;
    r_mode = 2'd0;
    tick();
    sb.push_back('{tt: NOR2_TT, pass: 1'b1, err: 2'd0, sweep: 16'd1});
    launch(NOR2_TT, 1'b0);
    wait_done(1, lat);
    chk("t6_latency", lat, 32'd10);
    score("t6");
    tick();

    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer for one 2-input combinational gate cell from the gate library (e.g. the NOR2 cell).
- Drives the gate's a/b inputs through all four combinations, waits a settle time per vector, samples y, and assembles a 4-bit truth table.
- Compares the table against an expected table and reports pass/fail plus a saturating error count.
- Sits between a host/start source and the gate under test on the FPGA bring-up board.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before y is sampled (min 1).
- ERR_W, 8, width of the mismatch counter.
- SWEEP_W, 16, width of the completed-sweep counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin sweep; sampled only in IDLE.
- cont  input  1  continuous mode; sampled with start and again at each CHECK.
- abort  input  1  synchronous abort; returns to IDLE.
- expect_tt  input  4  expected truth table, index {a,b}; latched on start.
- gate_a  output  1  drive to gate input a.
- gate_b  output  1  drive to gate input b.
- gate_y  input  1  gate output, same clock domain, combinational path.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  last CHECK result; held until next start.
- result_tt  output  4  last captured truth table.
- err_cnt  output  ERR_W  saturating mismatch count.
- sweep_cnt  output  SWEEP_W  completed sweeps, wraps at 2^SWEEP_W.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State returns to IDLE.
  - All outputs go to 0: gate_a, gate_b, busy, done, pass, result_tt, err_cnt, sweep_cnt.
  - The idx register and the settle timer are cleared.
  - Reset takes priority over abort, which takes priority over start.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - gate_a=gate_b=0.
  - On start=1: latch expect_tt and cont, clear err_cnt and sweep_cnt, set idx=0, load timer, go to SETTLE.
- SETTLE:
  - {gate_a,gate_b}=idx; the outputs are registered and change on the entering edge.
  - Timer counts SETTLE_CYCLES cycles.
  - On the last cycle, tt[idx]<=gate_y.
  - If idx==3, go to CHECK. Otherwise idx++, reload the timer, and stay in SETTLE.
  - The vector is held for exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - result_tt<=tt; pass<=(tt==latched expect_tt).
  - On mismatch, err_cnt increments and saturates at all-ones.
  - sweep_cnt increments.
  - If latched cont=1 and cont input=1, set idx=0 and go to SETTLE. Otherwise go to DONE.
  - Once cont is dropped, it cannot be re-armed mid-run.
- DONE (1 cycle): done=1, then return to IDLE.
- Single-sweep latency: done is high exactly 4*SETTLE_CYCLES+2 cycles after the edge that samples start (10 cycles at the default).
- start while busy is ignored.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, with gate_a/b=0 and no done pulse.
  - pass, result_tt, err_cnt and sweep_cnt keep their last values; a partial tt is discarded.
- expect_tt changes after start have no effect.

Decomposition:
- Shared package gate_lib_pkg holds:
  - the state enum;
  - TT_W=4;
  - truth-table constants NOR2_TT=4'b0001, OR2_TT=4'b1110, AND2_TT=4'b1000, NAND2_TT=4'b0111, XOR2_TT=4'b0110.
- One sub-module, settle_timer: a loadable down-counter with a terminal-count output, width $clog2(SETTLE_CYCLES+1).

Test Plan:
- NOR2 cell as the gate under test, expect_tt=NOR2_TT, one start pulse:
  - gate_a/b step through 00,01,10,11, two cycles each.
  - done high 10 cycles after start; pass=1, result_tt=0001, err_cnt=0, sweep_cnt=1.
- NOR2 cell, expect_tt=AND2_TT:
  - pass=0, result_tt=0001, err_cnt=1.
- gate_y tied to 1 (stuck-at fault), expect NOR2_TT:
  - result_tt=1111, pass=0.
- ERR_W=2, gate_y stuck at 0, cont=1 held for 5 sweeps, then dropped:
  - err_cnt saturates at 3, sweep_cnt=5.
  - Exactly one done pulse after the last CHECK.
- abort asserted in the third vector's SETTLE:
  - IDLE next cycle, gate_a/b=0, no done.
  - result_tt/pass unchanged from the previous run.
  - A start during the aborted run had no effect.
- rst_n=0 for one cycle mid-sweep:
  - All outputs 0 on the next cycle.
  - A subsequent start runs a clean sweep with done at +10.
